gshare_bp: RTL

- Parametrised gshare branch direction predictor for the pipelined CPU.
- PHT index = PC word bits XOR global history; counters are CTR_W-bit saturating.
- History updates speculatively at fetch and is repaired from a checkpoint on mispredict.
- Clears the PHT with a post-reset sweep FSM, so the array is valid without initial blocks.
- Sits in IF (predict port) and EX (resolve port).

---
 rtl/gshare_pkg.sv | 24 ++
 rtl/gshare_pht.sv | 34 +++
 rtl/gshare_bp.sv | 129 ++++++++++++
 3 files changed

// File: rtl/gshare_pkg.sv
// Shared types, defaults and counter helper for the gshare predictor.
// Optional GSHARE_STATS_EN adds branch/mispredict counters on the top.
package gshare_pkg;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam int DEF_IDX_W    = 8;
   localparam int DEF_HIST_W   = 8;
   localparam int DEF_CTR_W    = 2;
   localparam int DEF_INIT_CTR = 1;

   // Saturating step of a w-bit counter, carried as int to stay width-agnostic.
   function automatic int ctr_sat(input int c, input logic up, input int w);
      int mx;
      mx = (1 << w) - 1;
      if (up)
         return (c >= mx) ? mx : c + 1;
      return (c <= 0) ? 0 : c - 1;
   endfunction

endpackage

// File: rtl/gshare_pht.sv
// Pattern history table: async read, one write port shared by the
// init sweep and training; reads see the pre-write value.
module gshare_pht
   import gshare_pkg::*;
#(
   parameter int IDX_W = DEF_IDX_W,
   parameter int CTR_W = DEF_CTR_W
) (
   input  logic             clk,
   input  logic [IDX_W-1:0] i_raddr,
   output logic [CTR_W-1:0] o_rdata,
   input  logic             i_we,
   input  logic             i_init,
   input  logic [IDX_W-1:0] i_waddr,
   input  logic [CTR_W-1:0] i_init_val,
   input  logic             i_up
);

   localparam int DEPTH = 1 << IDX_W;

   logic [CTR_W-1:0] r_mem [DEPTH];
   logic [CTR_W-1:0] w_wdata;

   assign o_rdata = r_mem[i_raddr];

   assign w_wdata = i_init ? i_init_val
                  : CTR_W'(ctr_sat(int'(r_mem[i_waddr]), i_up, CTR_W));

   always_ff @(posedge clk) begin
      if (i_we)
         r_mem[i_waddr] <= w_wdata;
   end

endmodule

// File: rtl/gshare_bp.sv
// gshare direction predictor: init sweep FSM, speculative GHR with repair.
// Define GSHARE_STATS_EN to add stat_branches / stat_mispredicts outputs.
module gshare_bp
   import gshare_pkg::*;
#(
   parameter int IDX_W    = DEF_IDX_W,
   parameter int HIST_W   = DEF_HIST_W,
   parameter int CTR_W    = DEF_CTR_W,
   parameter int INIT_CTR = DEF_INIT_CTR
) (
   input  logic              clk,
   input  logic              rst,
   output logic              ready,
   input  logic              pred_valid,
   input  logic [31:0]       pred_pc,
   output logic              pred_taken,
   output logic [IDX_W-1:0]  pred_idx,
   output logic [HIST_W-1:0] pred_ghr,
   input  logic              upd_valid,
   input  logic [IDX_W-1:0]  upd_idx,
   input  logic [HIST_W-1:0] upd_ghr,
   input  logic              upd_taken,
   input  logic              upd_mispredict
`ifdef GSHARE_STATS_EN
   ,
   output logic [31:0]       stat_branches,
   output logic [31:0]       stat_mispredicts
`endif
);

   localparam logic [IDX_W-1:0] LAST = '1;

   state_t            r_state;
   logic              r_ready;
   logic [IDX_W-1:0]  r_sweep;
   logic [HIST_W-1:0] r_ghr;

   logic [HIST_W-1:0] w_spec;
   logic [HIST_W-1:0] w_repair;
   logic [CTR_W-1:0]  w_rdata;
   logic [IDX_W-1:0]  w_waddr;
   logic              w_we;
   logic              w_repair_en;
   logic              w_unused;

   assign ready       = r_ready;
   assign pred_idx    = pred_pc[IDX_W+1:2] ^ IDX_W'(r_ghr);
   assign pred_ghr    = r_ghr;
   assign pred_taken  = r_ready & w_rdata[CTR_W-1];
   assign w_repair_en = upd_valid & upd_mispredict;
   assign w_we        = ~r_ready | upd_valid;
   assign w_waddr     = r_ready ? upd_idx : r_sweep;

   assign w_unused = ^{pred_pc[31:IDX_W+2], pred_pc[1:0], upd_ghr, w_rdata};

   generate
      if (HIST_W == 1) begin : g_h1
         assign w_spec   = pred_taken;
         assign w_repair = upd_taken;
      end else begin : g_hn
         assign w_spec   = {r_ghr[HIST_W-2:0], pred_taken};
         assign w_repair = {upd_ghr[HIST_W-2:0], upd_taken};
      end
   endgenerate

   gshare_pht #(
      .IDX_W (IDX_W),
      .CTR_W (CTR_W)
   ) u_pht (
      .clk        (clk),
      .i_raddr    (pred_idx),
      .o_rdata    (w_rdata),
      .i_we       (w_we),
      .i_init     (~r_ready),
      .i_waddr    (w_waddr),
      .i_init_val (CTR_W'(INIT_CTR)),
      .i_up       (upd_taken)
   );

   // Repair wins over the speculative shift: that fetch is on the wrong path.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_INIT;
         r_ready <= 1'b0;
         r_sweep <= '0;
         r_ghr   <= '0;
      end else begin
         unique case (r_state)
            ST_INIT: begin
               r_sweep <= r_sweep + IDX_W'(1);
               if (r_sweep == LAST) begin
                  r_state <= ST_RUN;
                  r_ready <= 1'b1;
               end
            end
            ST_RUN: begin
               if (w_repair_en)
                  r_ghr <= w_repair;
               else if (pred_valid)
                  r_ghr <= w_spec;
            end
            default: begin
               r_state <= ST_INIT;
            end
         endcase
      end
   end

`ifdef GSHARE_STATS_EN
   logic [31:0] r_stat_br;
   logic [31:0] r_stat_mp;

   assign stat_branches    = r_stat_br;
   assign stat_mispredicts = r_stat_mp;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stat_br <= '0;
         r_stat_mp <= '0;
      end else if (upd_valid && r_ready) begin
         if (r_stat_br != 32'hFFFF_FFFF)
            r_stat_br <= r_stat_br + 32'd1;
         if (upd_mispredict && r_stat_mp != 32'hFFFF_FFFF)
            r_stat_mp <= r_stat_mp + 32'd1;
      end
   end
`endif

endmodule
